// File: rtl/shake_arbiter_if.sv
// shake_arbiter_if
// Bundles every handshake/bus signal between the sampler blocks, the arbiter
// and the single SHAKE core.
//   req/gnt              : per-requester session request and one-hot grant
//   r_*                  : requester-side absorb/squeeze handshake, one bit
//                          (or one slice) per requester
//   s_*                  : core-side handshake towards the shared SHAKE core
// The master modport is the arbiter's view and the slave modport is the
// environment's view (samplers plus core).
interface shake_arbiter_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1
);

  // Requester side
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              r_force_rst;
  logic [NUM_REQ*DATA_IN_BITS-1:0] r_data_in;
  logic [NUM_REQ-1:0]              r_in_valid;
  logic [NUM_REQ-1:0]              r_in_last;
  logic [NUM_REQ-1:0]              r_out_ready;
  logic [NUM_REQ*LEN_W-1:0]        r_last_len;
  logic [NUM_REQ-1:0]              r_in_ready;
  logic [NUM_REQ-1:0]              r_out_valid;
  logic [DATA_OUT_BITS-1:0]        r_data_out;

  // Core side
  logic                     s_force_rst;
  logic [DATA_IN_BITS-1:0]  s_data_in;
  logic                     s_in_valid;
  logic                     s_in_last;
  logic                     s_out_ready;
  logic [LEN_W-1:0]         s_last_len;
  logic                     s_in_ready;
  logic                     s_out_valid;
  logic [DATA_OUT_BITS-1:0] s_data_out;

  modport master (
    input  req, r_force_rst, r_data_in, r_in_valid, r_in_last, r_out_ready,
           r_last_len, s_in_ready, s_out_valid, s_data_out,
    output gnt, r_in_ready, r_out_valid, r_data_out, s_force_rst, s_data_in,
           s_in_valid, s_in_last, s_out_ready, s_last_len
  );

  modport slave (
    output req, r_force_rst, r_data_in, r_in_valid, r_in_last, r_out_ready,
           r_last_len, s_in_ready, s_out_valid, s_data_out,
    input  gnt, r_in_ready, r_out_valid, r_data_out, s_force_rst, s_data_in,
           s_in_valid, s_in_last, s_out_ready, s_last_len
  );

endinterface

// File: rtl/shake_arbiter.sv
// shake_arbiter
// Round-robin arbiter sharing one SHAKE core between NUM_REQ sampler blocks.
// An owner keeps the core for its whole session (absorb, squeezes and
// re-absorbs); every new owner is preceded by a one-cycle core restart.
// Ports:
//   clk      : clock, all logic on posedge
//   rst      : synchronous active-high reset
//   bus      : shake_arbiter_if.master (requester and core handshakes)
//   busy_o   : high whenever the arbiter is not idle
//   owner_o  : index of the current (or most recent) owner
module shake_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_IN_BITS  = 64,
  parameter int DATA_OUT_BITS = 64,
  parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1,
  parameter int IDX_W         = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  shake_arbiter_if.master       bus,
  output logic                  busy_o,
  output logic [IDX_W-1:0]      owner_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    OWN   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   winner;
  logic               found;

  // Round-robin search: the first requester at or after rr_ptr wins,
  // wrapping around the requester list.
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        winner = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        found  = 1'b1;
      end
    end
  end

  // State, owner, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  // Next-state logic. The pointer only advances when a real session ends,
  // so a request abandoned during FLUSH does not cost anyone their turn.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          owner_d = winner;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (bus.req[owner_q]) begin
          gnt_d   = NUM_REQ'(1) << owner_q;
          state_d = OWN;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      OWN: begin
        if (!bus.req[owner_q]) begin
          gnt_d    = '0;
          rr_ptr_d = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
          state_d  = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath steering, purely combinational from the registered state and
  // owner so data/valid/ready/last see no added latency. Only the owner is
  // connected to the core; everything else reads as zero.
  always_comb begin
    bus.s_force_rst = 1'b0;
    bus.s_data_in   = '0;
    bus.s_in_valid  = 1'b0;
    bus.s_in_last   = 1'b0;
    bus.s_out_ready = 1'b0;
    bus.s_last_len  = '0;
    bus.r_in_ready  = '0;
    bus.r_out_valid = '0;
    if (state_q == FLUSH) begin
      bus.s_force_rst = 1'b1;
    end else if (state_q == OWN) begin
      bus.s_force_rst = bus.r_force_rst[owner_q];
      bus.s_data_in   = bus.r_data_in[owner_q*DATA_IN_BITS +: DATA_IN_BITS];
      bus.s_in_valid  = bus.r_in_valid[owner_q];
      bus.s_in_last   = bus.r_in_last[owner_q];
      bus.s_out_ready = bus.r_out_ready[owner_q];
      bus.s_last_len  = bus.r_last_len[owner_q*LEN_W +: LEN_W];
      bus.r_in_ready  = NUM_REQ'(bus.s_in_ready) << owner_q;
      bus.r_out_valid = NUM_REQ'(bus.s_out_valid) << owner_q;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.r_data_out = bus.s_data_out;
  assign busy_o         = (state_q != IDLE);
  assign owner_o        = owner_q;

endmodule

// File: tb/tb_shake_arbiter.sv
// tb_shake_arbiter
// Directed bench for shake_arbiter: single-requester absorb, round-robin
// order, FLUSH abort, no preemption, squeeze gating and reset mid-session.
module tb_shake_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DIB     = 64;
  localparam int DOB     = 64;
  localparam int LEN_W   = 7;
  localparam int IDX_W   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy_o;
  logic [IDX_W-1:0] owner_o;
  logic [3:0]       expGnt;
  logic [63:0]      expWord;
  int               totalChecks = 0;
  int               badChecks   = 0;

  shake_arbiter_if #(
    .NUM_REQ(NUM_REQ), .DATA_IN_BITS(DIB), .DATA_OUT_BITS(DOB), .LEN_W(LEN_W)
  ) bus ();

  shake_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_IN_BITS(DIB), .DATA_OUT_BITS(DOB),
    .LEN_W(LEN_W), .IDX_W(IDX_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .busy_o  (busy_o),
    .owner_o (owner_o)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Single comparison point; every check is counted here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the request vector and let the combinational outputs settle.
  task automatic applyStimulus(input logic [3:0] reqVal);
    bus.req = reqVal;
    #1;
  endtask

  task automatic clearInputs();
    bus.req         = '0;
    bus.r_force_rst = '0;
    bus.r_data_in   = '0;
    bus.r_in_valid  = '0;
    bus.r_in_last   = '0;
    bus.r_out_ready = '0;
    bus.r_last_len  = '0;
    bus.s_in_ready  = 1'b0;
    bus.s_out_valid = 1'b0;
    bus.s_data_out  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    clearInputs();
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    doReset();
    rst = 1'b1;
    #1;
    checkOutput("reset gnt", bus.gnt, 0);
    checkOutput("reset busy", busy_o, 0);
    checkOutput("reset owner", owner_o, 0);
    checkOutput("reset s_force_rst", bus.s_force_rst, 0);
    checkOutput("reset s_in_valid", bus.s_in_valid, 0);
    checkOutput("reset r_in_ready", bus.r_in_ready, 0);
    rst = 1'b0;

    // Single requester 2: FLUSH at t+1, grant at t+2, then 9 absorb words
    applyStimulus(4'b0100);
    checkOutput("single t0 gnt", bus.gnt, 0);
    checkOutput("single t0 busy", busy_o, 0);
    nextCycle();
    checkOutput("single flush busy", busy_o, 1);
    checkOutput("single flush force", bus.s_force_rst, 1);
    checkOutput("single flush gnt", bus.gnt, 0);
    checkOutput("single flush owner", owner_o, 2);
    nextCycle();
    checkOutput("single own gnt", bus.gnt, 4'b0100);
    checkOutput("single own force", bus.s_force_rst, 0);
    bus.s_in_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      expWord = {32'h01234567, 32'(i)};
      bus.r_data_in[2*DIB +: DIB]     = expWord;
      bus.r_data_in[0 +: DIB]         = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.r_last_len[2*LEN_W +: LEN_W] = 7'(i + 1);
      bus.r_in_valid = 4'b0101;
      bus.r_in_last  = (i == 8) ? 4'b0100 : 4'b0001;
      #1;
      checkOutput("absorb data", bus.s_data_in, expWord);
      checkOutput("absorb valid", bus.s_in_valid, 1);
      checkOutput("absorb last", bus.s_in_last, (i == 8) ? 64'd1 : 64'd0);
      checkOutput("absorb len", bus.s_last_len, 64'(i + 1));
      checkOutput("absorb in_ready", bus.r_in_ready, 4'b0100);
      nextCycle();
    end
    clearInputs();
    applyStimulus(4'b0000);
    nextCycle();
    checkOutput("single release gnt", bus.gnt, 0);
    checkOutput("single release busy", busy_o, 0);
    checkOutput("single release in_ready", bus.r_in_ready, 0);

    // Round robin: all four requesting, each owner holds 5 cycles
    doReset();
    applyStimulus(4'b1111);
    nextCycle();
    checkOutput("rr first flush", bus.s_force_rst, 1);
    nextCycle();
    for (int s = 0; s < 5; s++) begin
      expGnt = 4'b0001 << (s % 4);
      checkOutput("rr gnt", bus.gnt, expGnt);
      checkOutput("rr owner", owner_o, 64'(s % 4));
      repeat (4) nextCycle();
      checkOutput("rr hold gnt", bus.gnt, expGnt);
      applyStimulus(4'b1111 & ~expGnt);
      nextCycle();
      checkOutput("rr idle gnt", bus.gnt, 0);
      checkOutput("rr idle busy", busy_o, 0);
      applyStimulus(4'b1111);
      nextCycle();
      checkOutput("rr flush force", bus.s_force_rst, 1);
      checkOutput("rr flush gnt", bus.gnt, 0);
      nextCycle();
    end
    applyStimulus(4'b0000);
    nextCycle();

    // Abort in FLUSH: requester 3 pulses for one cycle
    doReset();
    applyStimulus(4'b1000);
    nextCycle();
    checkOutput("abort flush busy", busy_o, 1);
    checkOutput("abort flush force", bus.s_force_rst, 1);
    checkOutput("abort flush owner", owner_o, 3);
    applyStimulus(4'b0000);
    nextCycle();
    checkOutput("abort idle busy", busy_o, 0);
    checkOutput("abort idle gnt", bus.gnt, 0);
    nextCycle();
    checkOutput("abort still no gnt", bus.gnt, 0);
    applyStimulus(4'b1001);
    nextCycle();
    checkOutput("abort next owner", owner_o, 0);
    nextCycle();
    checkOutput("abort next gnt", bus.gnt, 4'b0001);
    applyStimulus(4'b0000);
    nextCycle();
    checkOutput("abort release gnt", bus.gnt, 0);

    // No preemption plus squeeze gating with owner 1
    applyStimulus(4'b0010);
    nextCycle();
    nextCycle();
    checkOutput("npre own gnt", bus.gnt, 4'b0010);
    applyStimulus(4'b0011);
    for (int c = 0; c < 3; c++) begin
      nextCycle();
      checkOutput("npre hold gnt", bus.gnt, 4'b0010);
    end
    bus.s_out_valid = 1'b1;
    bus.s_data_out  = 64'hDEADBEEF;
    bus.r_out_ready = 4'b0010;
    #1;
    checkOutput("squeeze out_valid", bus.r_out_valid, 4'b0010);
    checkOutput("squeeze data_out", bus.r_data_out, 64'hDEADBEEF);
    checkOutput("squeeze out_ready", bus.s_out_ready, 1);
    bus.r_out_ready = 4'b0001;
    #1;
    checkOutput("squeeze nonowner ready", bus.s_out_ready, 0);
    bus.r_force_rst = 4'b0010;
    #1;
    checkOutput("owner force passthru", bus.s_force_rst, 1);
    bus.r_force_rst = 4'b0001;
    #1;
    checkOutput("nonowner force ignored", bus.s_force_rst, 0);
    clearInputs();
    applyStimulus(4'b0001);
    nextCycle();
    checkOutput("npre idle gnt", bus.gnt, 0);
    checkOutput("npre idle busy", busy_o, 0);
    nextCycle();
    checkOutput("npre flush force", bus.s_force_rst, 1);
    checkOutput("npre flush owner", owner_o, 0);
    nextCycle();
    checkOutput("npre handoff gnt", bus.gnt, 4'b0001);
    applyStimulus(4'b0000);
    nextCycle();

    // Reset during an active session of owner 1
    applyStimulus(4'b0010);
    nextCycle();
    nextCycle();
    checkOutput("rstmid own gnt", bus.gnt, 4'b0010);
    bus.r_in_valid = 4'b0010;
    #1;
    checkOutput("rstmid own valid", bus.s_in_valid, 1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rstmid gnt", bus.gnt, 0);
    checkOutput("rstmid busy", busy_o, 0);
    checkOutput("rstmid s_in_valid", bus.s_in_valid, 0);
    checkOutput("rstmid owner", owner_o, 0);
    rst = 1'b0;
    bus.r_in_valid = '0;
    applyStimulus(4'b0100);
    nextCycle();
    checkOutput("rstmid flush force", bus.s_force_rst, 1);
    checkOutput("rstmid flush gnt", bus.gnt, 0);
    nextCycle();
    checkOutput("rstmid regrant gnt", bus.gnt, 4'b0100);
    checkOutput("rstmid regrant owner", owner_o, 2);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/shake_arbiter.md
# shake_arbiter

Round-robin arbiter that shares one SHAKE core between up to NUM_REQ sampler blocks (ExpandA, ExpandS, ExpandMask, SampleInBall, …). A requester holds exclusive ownership for a whole session: absorb, any number of squeezes, and any per-polynomial re-absorbs. The arbiter forces a core reset before every new owner and steers handshake signals only to the owner. It sits between the samplers and the single shake instance in the key-generation/signing top level.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- DATA_IN_BITS, 64, absorb word width
- DATA_OUT_BITS, 64, squeeze word width
- LEN_W, $clog2(DATA_IN_BITS)+1, width of last_len
- IDX_W, $clog2(NUM_REQ), owner index width
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  session request, one bit per requester, level
- gnt  out  NUM_REQ  one-hot grant, registered
- busy  out  1  any grant or flush in progress
- owner  out  IDX_W  index of current/last owner
- r_force_rst  in  NUM_REQ  per-requester core restart (absorb_next_poly)
- r_data_in  in  NUM_REQ*DATA_IN_BITS  requester i at slice [i*DATA_IN_BITS +: DATA_IN_BITS]
- r_in_valid, r_in_last, r_out_ready  in  NUM_REQ each
- r_last_len  in  NUM_REQ*LEN_W
- r_in_ready, r_out_valid  out  NUM_REQ each; gated to owner
- r_data_out  out  DATA_OUT_BITS  broadcast core data_out
- s_force_rst  out  1  core restart
- s_data_in  out  DATA_IN_BITS;  s_in_valid, s_in_last, s_out_ready  out  1;  s_last_len  out  LEN_W
- s_in_ready, s_out_valid  in  1;  s_data_out  in  DATA_OUT_BITS

## Operation
- States: IDLE, FLUSH, OWN.
- IDLE: if any req, pick the winner = first set bit at or after rr_ptr, wrapping modulo NUM_REQ; latch owner; go to FLUSH. No req: stay.
- FLUSH (exactly 1 cycle): s_force_rst=1, all s_* valid/ready=0. Next: OWN with gnt[owner]=1. If req[owner] dropped during FLUSH: go to IDLE, no grant, rr_ptr unchanged.
- OWN: s_data_in, s_in_valid, s_in_last, s_last_len, s_out_ready, s_force_rst = owner's inputs. r_in_ready[owner]=s_in_ready, r_out_valid[owner]=s_out_valid; the same bits for non-owners are 0. Non-owner inputs are ignored.
- OWN exit: when req[owner]=0, clear gnt next cycle, rr_ptr ← (owner+1) mod NUM_REQ, go to IDLE. New requests never preempt the owner.
- Outside OWN: every s_* output = 0 except s_force_rst in FLUSH; all r_in_ready/r_out_valid = 0.
- busy = (state != IDLE).
- Reset: state=IDLE, gnt=0, owner=0, rr_ptr=0, busy=0, s_force_rst=0, every s_* and r_* output 0 (r_data_out mirrors s_data_out). Reset during OWN drops the grant the next cycle; the requester must restart its session.

## Timing
- req[i] rises at cycle t with arbiter IDLE → state=FLUSH and s_force_rst=1 in cycle t+1 → gnt[i]=1 in cycle t+2. Minimum grant latency is 2 cycles.
- Datapath muxing is combinational from the registered owner/state. There is zero added latency on data, valid, ready and last.
- req[owner] falls in cycle t → gnt=0, IDLE in t+1. The earliest next FLUSH is t+2, so at least one idle cycle separates sessions.
- Requester contract: do not assert r_in_valid/r_out_ready before gnt; deassert req only when no core transfer is pending.
- Simultaneous requests: resolved strictly by rr_ptr order. A requester reasserting req right after release waits behind every other pending requester.

## Test plan
- Single requester: req[2]=1 at t=0 → s_force_rst pulse at t=1, gnt=4'b0100 at t=2. Drive 9 absorb words with in_last on the 9th; they appear unchanged on s_*. r_in_ready[0,1,3] stay 0 throughout.
- Round-robin: req=4'b1111 held, each owner releases after 5 cycles → grant order 0,1,2,3,0. One FLUSH cycle before each grant, one IDLE cycle between sessions.
- No preemption: owner 1 active, req[0] rises → gnt stays 4'b0010 until req[1]=0, then req[0] is granted after FLUSH.
- Abort in FLUSH: req[3] pulses for 1 cycle → FLUSH, then IDLE. gnt never set, rr_ptr unchanged (next req=4'b1001 grants 0).
- Squeeze gating: owner 1, s_out_valid=1 with data 64'hDEADBEEF → r_out_valid=4'b0010, r_data_out=64'hDEADBEEF. Owner r_force_rst passes through to s_force_rst.
- Reset mid-session: rst=1 during OWN → next cycle gnt=0, busy=0, s_in_valid=0, owner=0. After rst release, req=4'b0100 grants 2 after 2 cycles.
